// File: rtl/lcd_pixel_source.sv
// RGB565 test-pattern frame source for the ILI9341 8080-bus writer (valid/ready stream).
// Optional macro LCD_TE_SYNC_EN: align each frame start to a rising edge of the panel TE pin.
module lcd_pixel_source #(
   parameter int H_RES   = 320,
   parameter int V_RES   = 240,
   parameter int BAR_W   = 40,
   parameter int GRID_SH = 4
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_lcd_fmark,
   input  logic        i_enable,
   input  logic [1:0]  i_pattern,
   input  logic [15:0] i_color,
   output logic [15:0] o_pix_data,
   output logic        o_pix_valid,
   input  logic        i_pix_ready,
   output logic        o_pix_sof,
   output logic        o_pix_eol,
   output logic        o_frame_done,
   output logic        o_busy
);
   localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
   localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
   localparam int BW = (BAR_W > 1) ? $clog2(BAR_W) : 1;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT_TE = 2'd1, S_STREAM = 2'd2, S_DONE = 2'd3} state_t;

   state_t          r_state;
   logic [XW-1:0]   r_x;
   logic [YW-1:0]   r_y;
   logic [BW-1:0]   r_bar_cnt;
   logic [3:0]      r_bar_k;
   logic [1:0]      r_pattern;
   logic [15:0]     r_color;

   logic [XW-1:0]   w_nx;
   logic [YW-1:0]   w_ny;
   logic [BW-1:0]   w_ncnt;
   logic [3:0]      w_nk;
   logic            w_last;
   logic            w_eol_next;
   logic            w_te_go;

   // Bar index k is tracked incrementally and saturates at 8 (black region past the bars).
   function automatic logic [15:0] f_pixel(input logic [1:0] pat, input logic [15:0] color,
                                           input logic [XW-1:0] x, input logic [YW-1:0] y,
                                           input logic [3:0] k);
      logic [15:0] pix;
      logic [4:0]  x_hi;
      logic [5:0]  y_hi;
      x_hi = 5'(x >> 4);
      y_hi = 6'(y >> 2);
      case (pat)
         2'd0: pix = color;
         2'd1: begin
            case (k)
               4'd0:    pix = 16'hFFFF;
               4'd1:    pix = 16'hFFE0;
               4'd2:    pix = 16'h07FF;
               4'd3:    pix = 16'h07E0;
               4'd4:    pix = 16'hF81F;
               4'd5:    pix = 16'hF800;
               4'd6:    pix = 16'h001F;
               default: pix = 16'h0000;
            endcase
         end
         2'd2: begin
            if (y[GRID_SH-1:0] == '0)      pix = 16'h001F;
            else if (x[GRID_SH-1:0] == '0) pix = 16'h07E0;
            else                           pix = 16'h0000;
         end
         default: pix = {x_hi, y_hi, x_hi};
      endcase
      return pix;
   endfunction

`ifdef LCD_TE_SYNC_EN
   logic r_te_s1, r_te_s2, r_te_prev, r_te_rise;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_te_s1   <= 1'b0;
         r_te_s2   <= 1'b0;
         r_te_prev <= 1'b0;
         r_te_rise <= 1'b0;
      end else begin
         r_te_s1   <= i_lcd_fmark;
         r_te_s2   <= r_te_s1;
         r_te_prev <= r_te_s2;
         r_te_rise <= r_te_s2 & ~r_te_prev;
      end
   end
   assign w_te_go = r_te_rise;
`else
   logic w_unused_fmark;
   assign w_unused_fmark = i_lcd_fmark;
   assign w_te_go        = 1'b1;
`endif

   // Position of the pixel that follows the one currently presented.
   always_comb begin
      w_nx       = '0;
      w_ny       = r_y;
      w_ncnt     = '0;
      w_nk       = 4'd0;
      w_last     = (r_x == XW'(H_RES - 1)) && (r_y == YW'(V_RES - 1));
      if (r_x == XW'(H_RES - 1)) begin
         w_ny = r_y + YW'(1);
      end else begin
         w_nx = r_x + XW'(1);
         if (r_bar_cnt == BW'(BAR_W - 1)) begin
            w_nk = (r_bar_k == 4'd8) ? 4'd8 : r_bar_k + 4'd1;
         end else begin
            w_ncnt = r_bar_cnt + BW'(1);
            w_nk   = r_bar_k;
         end
      end
      w_eol_next = (w_nx == XW'(H_RES - 1));
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= S_IDLE;
         r_x          <= '0;
         r_y          <= '0;
         r_bar_cnt    <= '0;
         r_bar_k      <= 4'd0;
         r_pattern    <= 2'd0;
         r_color      <= 16'h0000;
         o_pix_data   <= 16'h0000;
         o_pix_valid  <= 1'b0;
         o_pix_sof    <= 1'b0;
         o_pix_eol    <= 1'b0;
         o_frame_done <= 1'b0;
         o_busy       <= 1'b0;
      end else begin
         o_frame_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_enable) begin
                  r_state <= S_WAIT_TE;
                  o_busy  <= 1'b1;
               end
            end
            S_WAIT_TE: begin
               if (w_te_go) begin
                  r_state     <= S_STREAM;
                  r_pattern   <= i_pattern;
                  r_color     <= i_color;
                  r_x         <= '0;
                  r_y         <= '0;
                  r_bar_cnt   <= '0;
                  r_bar_k     <= 4'd0;
                  o_pix_data  <= f_pixel(i_pattern, i_color, '0, '0, 4'd0);
                  o_pix_valid <= 1'b1;
                  o_pix_sof   <= 1'b1;
                  o_pix_eol   <= (H_RES == 1);
               end
            end
            S_STREAM: begin
               if (i_pix_ready) begin
                  if (w_last) begin
                     r_state      <= S_DONE;
                     r_x          <= '0;
                     r_y          <= '0;
                     o_pix_valid  <= 1'b0;
                     o_pix_sof    <= 1'b0;
                     o_pix_eol    <= 1'b0;
                     o_pix_data   <= 16'h0000;
                     o_frame_done <= 1'b1;
                     o_busy       <= 1'b0;
                  end else begin
                     r_x        <= w_nx;
                     r_y        <= w_ny;
                     r_bar_cnt  <= w_ncnt;
                     r_bar_k    <= w_nk;
                     o_pix_data <= f_pixel(r_pattern, r_color, w_nx, w_ny, w_nk);
                     o_pix_sof  <= 1'b0;
                     o_pix_eol  <= w_eol_next;
                  end
               end
            end
            S_DONE: begin
               r_state <= i_enable ? S_WAIT_TE : S_IDLE;
               o_busy  <= i_enable;
            end
            default: begin
               r_state <= S_IDLE;
               o_busy  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_lcd_pixel_source.sv
// Randomized self-checking bench for lcd_pixel_source against a frame-level reference model.
// Works with or without LCD_TE_SYNC_EN defined.
module tb_lcd_pixel_source;
   localparam int H  = 320;
   localparam int V  = 6;
   localparam int BW = 40;
   localparam int GS = 4;
   localparam int BUDGET = H * V * 4 + 200;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fmark = 1'b0;
   logic        enable = 1'b0;
   logic        ready = 1'b0;
   logic [1:0]  pat = 2'd0;
   logic [15:0] col = 16'h0000;
   logic [15:0] pix_data;
   logic        pix_valid, pix_sof, pix_eol, frame_done, busy;

   always #5 clk = ~clk;

   lcd_pixel_source #(.H_RES(H), .V_RES(V), .BAR_W(BW), .GRID_SH(GS)) dut (
      .i_clk(clk), .i_reset(rst), .i_lcd_fmark(fmark), .i_enable(enable),
      .i_pattern(pat), .i_color(col), .o_pix_data(pix_data), .o_pix_valid(pix_valid),
      .i_pix_ready(ready), .o_pix_sof(pix_sof), .o_pix_eol(pix_eol),
      .o_frame_done(frame_done), .o_busy(busy));

   int          n_checks = 0;
   int          n_fail = 0;
   bit          mon_on = 1'b0;
   bit          rand_ready = 1'b0;
   int          mx = 0, my = 0, frame_acc = 0;
   bit          m_in_frame = 1'b0, done_pending = 1'b0, done_seen = 1'b0;
   int          m_pat = 0;
   logic [15:0] m_col = 16'h0000;
   logic [31:0] obs_sum = 32'd0;
   bit          prev_valid = 1'b0, prev_ready = 1'b0, prev_sof = 1'b0, prev_eol = 1'b0;
   logic [15:0] prev_data = 16'h0000;
   logic [15:0] img [V][H];
   logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                             16'hF81F, 16'hF800, 16'h001F, 16'h0000};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] ref_pix(input int p, input logic [15:0] c, input int x, input int y);
      int k;
      k = x / BW;
      if (p == 0)      return c;
      else if (p == 1) return (k < 8) ? bars[k] : 16'h0000;
      else if (p == 2) begin
         if (y % (1 << GS) == 0)      return 16'h001F;
         else if (x % (1 << GS) == 0) return 16'h07E0;
         else                         return 16'h0000;
      end
      else return 16'((((x >> 4) & 31) << 11) | (((y >> 2) & 63) << 5) | ((x >> 4) & 31));
   endfunction

   function automatic logic [31:0] ref_sum(input int p, input logic [15:0] c);
      logic [31:0] s;
      s = 32'd0;
      for (int y = 0; y < V; y++)
         for (int x = 0; x < H; x++)
            s = s + 32'(ref_pix(p, c, x, y));
      return s;
   endfunction

   // Per-cycle observation at the falling edge: scoreboard, hold rule, done pulse.
   task automatic monitor();
      if (!mon_on) return;
      check("frame_done", 32'(frame_done), 32'(done_pending));
      if (frame_done) begin
         done_seen = 1'b1;
         check("accepts", frame_acc, H * V);
         check("checksum", obs_sum, ref_sum(m_pat, m_col));
         check("busy_done", 32'(busy), 32'd0);
      end
      done_pending = 1'b0;
      if (prev_valid && !prev_ready) begin
         check("hold_valid", 32'(pix_valid), 32'd1);
         check("hold_data", 32'(pix_data), 32'(prev_data));
         check("hold_sof", 32'(pix_sof), 32'(prev_sof));
         check("hold_eol", 32'(pix_eol), 32'(prev_eol));
      end
      if (pix_valid) begin
         check("busy_stream", 32'(busy), 32'd1);
         if (!m_in_frame) begin
            m_in_frame = 1'b1;
            m_pat      = int'(pat);
            m_col      = col;
            frame_acc  = 0;
            obs_sum    = 32'd0;
         end
         if (ready) begin
            check("pix", 32'(pix_data), 32'(ref_pix(m_pat, m_col, mx, my)));
            check("sof", 32'(pix_sof), 32'(mx == 0 && my == 0));
            check("eol", 32'(pix_eol), 32'(mx == H - 1));
            img[my][mx] = pix_data;
            obs_sum     = obs_sum + 32'(pix_data);
            frame_acc++;
            if (mx == H - 1) begin
               mx = 0;
               if (my == V - 1) begin
                  my           = 0;
                  m_in_frame   = 1'b0;
                  done_pending = 1'b1;
               end else begin
                  my++;
               end
            end else begin
               mx++;
            end
         end
      end
      prev_valid = pix_valid;
      prev_ready = ready;
      prev_data  = pix_data;
      prev_sof   = pix_sof;
      prev_eol   = pix_eol;
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
      if (rand_ready) ready = ($urandom_range(0, 1) == 1);
      monitor();
   endtask

   task automatic model_clear();
      mx = 0; my = 0; frame_acc = 0;
      m_in_frame = 1'b0; done_pending = 1'b0; prev_valid = 1'b0;
   endtask

   task automatic pulse_te();
`ifdef LCD_TE_SYNC_EN
      fmark = 1'b1;
      repeat (3) cyc();
      fmark = 1'b0;
`endif
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (!pix_valid && n < 50) begin cyc(); n++; end
      if (!pix_valid) check("timeout_valid", 32'd1, 32'd0);
   endtask

   task automatic wait_frame_done();
      int n;
      n = 0;
      done_seen = 1'b0;
      while (!done_seen && n < BUDGET) begin cyc(); n++; end
      if (!done_seen) check("timeout_done", 32'd1, 32'd0);
   endtask

   task automatic start_frame();
      enable = 1'b1;
      pulse_te();
      wait_valid();
      enable = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      repeat (8) cyc();
      check({tag, "_valid"}, 32'(pix_valid), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int lat, gap, n;
      // Test 1: reset state, TE/start latency, solid frame
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_valid", 32'(pix_valid), 32'd0);
      check("rst_data", 32'(pix_data), 32'd0);
      check("rst_sof", 32'(pix_sof), 32'd0);
      check("rst_eol", 32'(pix_eol), 32'd0);
      check("rst_done", 32'(frame_done), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      model_clear();
      mon_on = 1'b1;
      pat = 2'd0; col = 16'hF800; ready = 1'b1;
      enable = 1'b1;
`ifdef LCD_TE_SYNC_EN
      repeat (5) cyc();
      check("wait_te_valid", 32'(pix_valid), 32'd0);
      check("wait_te_busy", 32'(busy), 32'd1);
      fmark = 1'b1;
      lat = 0;
      while (!pix_valid && lat < 20) begin cyc(); lat++; end
      check("te_latency", lat, 4);
      repeat (2) cyc();
      fmark = 1'b0;
`else
      lat = 0;
      while (!pix_valid && lat < 20) begin cyc(); lat++; end
      check("start_latency", lat, 2);
`endif
      enable = 1'b0;
      wait_frame_done();
      check_idle("t1_idle");

      // Test 2: colour bars and grid spot values
      pat = 2'd1;
      start_frame();
      wait_frame_done();
      check("bar_x0", 32'(img[0][0]), 32'h0000FFFF);
      check("bar_x39", 32'(img[0][39]), 32'h0000FFFF);
      check("bar_x40", 32'(img[0][40]), 32'h0000FFE0);
      check("bar_x200", 32'(img[3][200]), 32'h0000F800);
      check("bar_x319", 32'(img[0][319]), 32'h00000000);
      pat = 2'd2;
      start_frame();
      wait_frame_done();
      check("grid_5_0", 32'(img[0][5]), 32'h0000001F);
      check("grid_0_5", 32'(img[5][0]), 32'h000007E0);
      check("grid_16_5", 32'(img[5][16]), 32'h000007E0);
      check("grid_17_5", 32'(img[5][17]), 32'h00000000);
      check_idle("t2_idle");

      // Test 3: gradient with random backpressure
      pat = 2'd3;
      rand_ready = 1'b1;
      start_frame();
      wait_frame_done();
      rand_ready = 1'b0;
      ready = 1'b1;
      check_idle("t3_idle");

      // Test 4: reset mid-frame, then clean restart
      pat = 2'd1;
      start_frame();
      enable = 1'b1;
      n = 0;
      while (!(mx == 100 && my == 3) && n < BUDGET) begin cyc(); n++; end
      check("reach_100_3", 32'(mx == 100 && my == 3), 32'd1);
      rst = 1'b1;
      mon_on = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("midrst_valid", 32'(pix_valid), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(frame_done), 32'd0);
      rst = 1'b0;
      model_clear();
      mon_on = 1'b1;
      pulse_te();
      wait_valid();
      check("restart_sof", 32'(pix_sof), 32'd1);
      enable = 1'b0;
      wait_frame_done();
      check_idle("t4_idle");

      // Test 5: mid-frame setting changes, enable drop and stray TE are ignored
      pat = 2'd0; col = 16'h1234;
      start_frame();
      n = 0;
      while (my != 2 && n < BUDGET) begin cyc(); n++; end
      pat = 2'd2; col = 16'hABCD;
      pulse_te();
      wait_frame_done();
      check_idle("t5_idle");

`ifndef LCD_TE_SYNC_EN
      // Test 6: back-to-back frames with a two-cycle gap
      pat = 2'd3;
      enable = 1'b1;
      wait_frame_done();
      gap = 1;
      n = 0;
      while (n < 20) begin
         cyc();
         n++;
         if (pix_valid) break;
         gap++;
      end
      check("frame_gap", gap, 2);
      enable = 1'b0;
      wait_frame_done();
      check_idle("t6_idle");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
